// File: rtl/xnor_match_tracker.sv
// Purpose: popcount and lock tracking of an XNOR match vector; optional err_cnt under XNOR_MATCH_ERRCNT_EN.
// Latency: 1 cycle from accepted sample to valid_out with updated results.
// Backpressure: none; a sample is accepted on every cycle with valid_in=1.
module xnor_match_tracker #(
    parameter int n        = 4,
    parameter int RUN_LEN  = 3,
    parameter int MISS_LIM = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         valid_in,
    input  logic [n-1:0]                 F_in,
    output logic                         valid_out,
    output logic [$clog2(n+1)-1:0]       ones_cnt,
    output logic                         all_match,
    output logic [$clog2(RUN_LEN+1)-1:0] run_cnt,
`ifdef XNOR_MATCH_ERRCNT_EN
    output logic [15:0]                  err_cnt,
`endif
    output logic                         locked
);

    localparam int CW = $clog2(n + 1);
    localparam int RW = $clog2(RUN_LEN + 1);
    localparam int MW = $clog2(MISS_LIM + 1);

    localparam logic [CW-1:0] N_CNT    = CW'(n);
    localparam logic [RW-1:0] RUN_MAX  = RW'(RUN_LEN);
    localparam logic [MW-1:0] MISS_MAX = MW'(MISS_LIM);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] run_cnt_q, run_cnt_d;
    logic [MW-1:0] miss_cnt_q, miss_cnt_d;
    logic [CW-1:0] ones_cnt_q, ones_cnt_d;
    logic          all_match_q, all_match_d;
    logic          valid_out_q, valid_out_d;
    logic          locked_q, locked_d;

    logic [CW-1:0] popcnt;
    logic          full;
    logic [RW-1:0] run_inc;
    logic [MW-1:0] miss_inc;

`ifdef XNOR_MATCH_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [16:0] err_sum;
`endif

    always_comb begin
        popcnt = '0;
        for (int i = 0; i < n; i++) begin
            popcnt = popcnt + CW'(F_in[i]);
        end
    end

    assign full     = &F_in;
    assign run_inc  = run_cnt_q + RW'(1);
    assign miss_inc = miss_cnt_q + MW'(1);

`ifdef XNOR_MATCH_ERRCNT_EN
    // Mismatched bits are n - popcount; one extra bit detects wrap for saturation.
    assign err_sum = {1'b0, err_cnt_q} + 17'(N_CNT - popcnt);
`endif

    always_comb begin
        state_d     = state_q;
        run_cnt_d   = run_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        ones_cnt_d  = ones_cnt_q;
        all_match_d = all_match_q;
        valid_out_d = 1'b0;
`ifdef XNOR_MATCH_ERRCNT_EN
        err_cnt_d   = err_cnt_q;
`endif

        if (clr) begin
            state_d     = SEARCH;
            run_cnt_d   = '0;
            miss_cnt_d  = '0;
            ones_cnt_d  = '0;
            all_match_d = 1'b0;
`ifdef XNOR_MATCH_ERRCNT_EN
            err_cnt_d   = '0;
`endif
        end else if (valid_in) begin
            valid_out_d = 1'b1;
            ones_cnt_d  = popcnt;
            all_match_d = (popcnt == N_CNT);
`ifdef XNOR_MATCH_ERRCNT_EN
            err_cnt_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
`endif
            case (state_q)
                SEARCH: begin
                    if (full) begin
                        run_cnt_d = RW'(1);
                        state_d   = (RUN_LEN == 1) ? LOCKED : CONFIRM;
                    end else begin
                        run_cnt_d = '0;
                    end
                end
                CONFIRM: begin
                    if (full) begin
                        run_cnt_d = run_inc;
                        if (run_inc == RUN_MAX) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        run_cnt_d = '0;
                        state_d   = SEARCH;
                    end
                end
                LOCKED: begin
                    if (full) begin
                        run_cnt_d = (run_cnt_q == RUN_MAX) ? RUN_MAX : run_inc;
                    end else begin
                        run_cnt_d = '0;
                        // A single miss drops lock outright when no hold window exists.
                        if (MISS_LIM == 1) begin
                            miss_cnt_d = '0;
                            state_d    = SEARCH;
                        end else begin
                            miss_cnt_d = MW'(1);
                            state_d    = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (full) begin
                        miss_cnt_d = '0;
                        run_cnt_d  = RW'(1);
                        state_d    = LOCKED;
                    end else if (miss_inc == MISS_MAX) begin
                        miss_cnt_d = '0;
                        state_d    = SEARCH;
                    end else begin
                        miss_cnt_d = miss_inc;
                    end
                end
                default: begin
                    state_d    = SEARCH;
                    run_cnt_d  = '0;
                    miss_cnt_d = '0;
                end
            endcase
        end

        locked_d = (state_d == LOCKED) || (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEARCH;
            run_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            ones_cnt_q  <= '0;
            all_match_q <= 1'b0;
            valid_out_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            ones_cnt_q  <= ones_cnt_d;
            all_match_q <= all_match_d;
            valid_out_q <= valid_out_d;
            locked_q    <= locked_d;
        end
    end

`ifdef XNOR_MATCH_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign valid_out = valid_out_q;
    assign ones_cnt  = ones_cnt_q;
    assign all_match = all_match_q;
    assign run_cnt   = run_cnt_q;
    assign locked    = locked_q;

endmodule
